// File: rtl/gbe_udp_tx_arb_if.sv
// Channel request/payload bundle and MAC byte stream for the
// UDP transmit arbiter.
interface gbe_udp_tx_arb_if #(
  parameter int N_CH = 2
);
  logic [N_CH-1:0]    ch_valid;
  logic [16*N_CH-1:0] ch_len;
  logic [32*N_CH-1:0] ch_destip;
  logic [16*N_CH-1:0] ch_destport;
  logic [8*N_CH-1:0]  ch_data;
  logic [N_CH-1:0]    ch_rd;
  logic [N_CH-1:0]    ch_done;
  logic [N_CH-1:0]    ch_err;
  logic [7:0]         mac_tx_data;
  logic               mac_tx_dvld;
  logic               mac_tx_ack;

  modport master (
    input  ch_valid,
    input  ch_len,
    input  ch_destip,
    input  ch_destport,
    input  ch_data,
    input  mac_tx_ack,
    output ch_rd,
    output ch_done,
    output ch_err,
    output mac_tx_data,
    output mac_tx_dvld
  );

  modport slave (
    output ch_valid,
    output ch_len,
    output ch_destip,
    output ch_destport,
    output ch_data,
    output mac_tx_ack,
    input  ch_rd,
    input  ch_done,
    input  ch_err,
    input  mac_tx_data,
    input  mac_tx_dvld
  );
endinterface

// File: rtl/gbe_udp_tx_arb.sv
// Round-robin UDP/IPv4 frame builder: arbitrates N_CH packet sources
// and streams Ethernet frames byte-wise to a GbE MAC.
module gbe_udp_tx_arb #(
  parameter int N_CH        = 2,
  parameter int MAX_PAYLOAD = 1472,
  parameter int IFG_CYCLES  = 12
) (
  input  logic        mac_clk,
  input  logic        mac_rst_n,
  gbe_udp_tx_arb_if.master bus,
  input  logic        local_enable,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [15:0] local_port,
  input  logic [7:0]  local_gateway,
  output logic [7:0]  arp_cache_addr,
  input  logic [47:0] arp_cache_rd_data,
  output logic [31:0] tx_pkt_count
);

  localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
  localparam int IFG_N = (IFG_CYCLES > 0) ? IFG_CYCLES : 1;
  localparam logic [15:0] IFG_LAST = 16'(IFG_N - 1);

  typedef enum logic [3:0] {
    IDLE, LOOKUP, CSUM, WAIT_ACK, HDR,
    DATA, PAD, DISCARD, GAP
  } state_t;

  state_t state, state_nx;

  logic [7:0]  data_a [N_CH];
  logic [15:0] len_a  [N_CH];
  logic [31:0] ip_a   [N_CH];
  logic [15:0] port_a [N_CH];

  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   pick;
  logic            pick_vld;
  logic [N_CH-1:0] hi_mask;

  logic [15:0] len_q;
  logic [31:0] destip_q;
  logic [15:0] destport_q;
  logic [47:0] dst_mac;
  logic [15:0] byte_idx;
  logic [1:0]  sub_q;
  logic [19:0] acc_q;
  logic [15:0] csum_q;
  logic [15:0] ip_id;
  logic [15:0] gap_q;

  logic [15:0]  sel_len;
  logic         bad_len;
  logic [15:0]  ip_len;
  logic [15:0]  udp_len;
  logic [19:0]  sum_w;
  logic [16:0]  fold1;
  logic [15:0]  fold2;
  logic [335:0] hdr;
  logic [5:0]   hsel;
  logic [7:0]   hbyte;
  logic         last_pay;

  logic [7:0]      tx_data;
  logic            tx_dvld;
  logic [N_CH-1:0] rd_v;
  logic [N_CH-1:0] done_v;
  logic [N_CH-1:0] err_v;
  logic            fin;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      data_a[i] = bus.ch_data[i*8 +: 8];
      len_a[i]  = bus.ch_len[i*16 +: 16];
      ip_a[i]   = bus.ch_destip[i*32 +: 32];
      port_a[i] = bus.ch_destport[i*16 +: 16];
    end
  end

  // Lowest requester above the last grant wins, else lowest overall.
  always_comb begin
    pick     = '0;
    pick_vld = |bus.ch_valid;
    for (int i = 0; i < N_CH; i++)
      hi_mask[i] = bus.ch_valid[i] && (i > int'(rr_ptr));
    for (int i = N_CH - 1; i >= 0; i--)
      if (bus.ch_valid[i]) pick = GW'(i);
    for (int i = N_CH - 1; i >= 0; i--)
      if (hi_mask[i]) pick = GW'(i);
  end

  assign sel_len = len_a[pick];
  assign bad_len = (sel_len == 16'd0) || (sel_len > MAX_LEN);

  assign arp_cache_addr =
    (destip_q[31:8] != local_ip[31:8]) ? local_gateway
                                       : destip_q[7:0];

  assign ip_len  = len_q + 16'd28;
  assign udp_len = len_q + 16'd8;

  assign sum_w = 20'h04500 + {4'd0, ip_len} + {4'd0, ip_id}
               + 20'h04000 + 20'h0FF11
               + {4'd0, local_ip[31:16]} + {4'd0, local_ip[15:0]}
               + {4'd0, destip_q[31:16]} + {4'd0, destip_q[15:0]};
  assign fold1 = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
  assign fold2 = acc_q[15:0] + {15'd0, acc_q[16]};

  assign hdr = {dst_mac, local_mac, 16'h0800,
                8'h45, 8'h00, ip_len, ip_id, 16'h4000,
                8'hFF, 8'h11, csum_q, local_ip, destip_q,
                local_port, destport_q, udp_len, 16'h0000};
  assign hsel  = 6'd41 - byte_idx[5:0];
  assign hbyte = hdr[{hsel, 3'b000} +: 8];

  assign last_pay = (byte_idx == len_q + 16'd41);

  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_data  = 8'h00;
    tx_dvld  = 1'b0;
    rd_v     = '0;
    done_v   = '0;
    err_v    = '0;
    fin      = 1'b0;
    unique case (state)
      IDLE: begin
        if (local_enable && pick_vld)
          state_nx = bad_len ? DISCARD : LOOKUP;
      end
      LOOKUP: begin
        if (sub_q == 2'd1) state_nx = CSUM;
      end
      CSUM: begin
        if (sub_q == 2'd2) state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        tx_dvld = 1'b1;
        tx_data = hbyte;
        if (bus.mac_tx_ack)
          state_nx = HDR;
        else if (!bus.ch_valid[grant_q])
          state_nx = IDLE;
      end
      HDR: begin
        tx_dvld = 1'b1;
        tx_data = hbyte;
        if (byte_idx == 16'd41) state_nx = DATA;
      end
      DATA: begin
        tx_dvld       = 1'b1;
        tx_data       = data_a[grant_q];
        rd_v[grant_q] = 1'b1;
        if (last_pay) begin
          if (len_q < 16'd18) begin
            state_nx = PAD;
          end else begin
            done_v[grant_q] = 1'b1;
            fin             = 1'b1;
            state_nx        = GAP;
          end
        end
      end
      PAD: begin
        tx_dvld = 1'b1;
        if (byte_idx == 16'd59) begin
          done_v[grant_q] = 1'b1;
          fin             = 1'b1;
          state_nx        = GAP;
        end
      end
      DISCARD: begin
        if (byte_idx == len_q) begin
          done_v[grant_q] = 1'b1;
          err_v[grant_q]  = 1'b1;
          state_nx        = IDLE;
        end else begin
          rd_v[grant_q] = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == IFG_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      grant_q      <= '0;
      rr_ptr       <= GW'(N_CH - 1);
      len_q        <= '0;
      destip_q     <= '0;
      destport_q   <= '0;
      dst_mac      <= '0;
      byte_idx     <= '0;
      sub_q        <= '0;
      acc_q        <= '0;
      csum_q       <= '0;
      ip_id        <= '0;
      gap_q        <= '0;
      tx_pkt_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (state_nx != IDLE) begin
            grant_q    <= pick;
            rr_ptr     <= pick;
            len_q      <= sel_len;
            destip_q   <= ip_a[pick];
            destport_q <= port_a[pick];
            sub_q      <= '0;
            byte_idx   <= '0;
          end
        end
        LOOKUP: begin
          sub_q <= sub_q + 2'd1;
          // Read data now reflects the address from the first cycle.
          if (sub_q == 2'd1) begin
            dst_mac <= arp_cache_rd_data;
            sub_q   <= '0;
          end
        end
        CSUM: begin
          sub_q <= sub_q + 2'd1;
          if (sub_q == 2'd0) acc_q <= sum_w;
          if (sub_q == 2'd1) acc_q <= {3'd0, fold1};
          if (sub_q == 2'd2) begin
            csum_q   <= ~fold2;
            byte_idx <= '0;
            sub_q    <= '0;
          end
        end
        WAIT_ACK: begin
          if (bus.mac_tx_ack) byte_idx <= 16'd1;
        end
        HDR, DATA, PAD: byte_idx <= byte_idx + 16'd1;
        DISCARD: begin
          if (byte_idx != len_q) byte_idx <= byte_idx + 16'd1;
        end
        GAP: gap_q <= gap_q + 16'd1;
        default: ;
      endcase
      if (fin) begin
        ip_id        <= ip_id + 16'd1;
        tx_pkt_count <= tx_pkt_count + 32'd1;
        gap_q        <= '0;
      end
    end
  end

  assign bus.mac_tx_data = tx_data;
  assign bus.mac_tx_dvld = tx_dvld;
  assign bus.ch_rd       = rd_v;
  assign bus.ch_done     = done_v;
  assign bus.ch_err      = err_v;

endmodule

// File: doc/gbe_udp_tx_arb.md
GBE_UDP_TX_ARB -- requirements
Module: gbe_udp_tx_arb

Interface
REQ-001 SHALL have parameter N_CH, 2, number of application channels (1..8).
REQ-002 SHALL have parameter MAX_PAYLOAD, 1472, largest accepted UDP payload in bytes.
REQ-003 SHALL have parameter IFG_CYCLES, 12, minimum mac_tx_dvld-low cycles between frames.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: mac_clk  in  1  sole clock; mac_rst_n  in  1  async active-low reset.
REQ-005 SHALL have these ports:
- ch_valid  in  N_CH  packet pending on channel i; header fields stable while high.
- ch_len  in  16*N_CH  payload bytes.
- ch_destip  in  32*N_CH  destination IP.
- ch_destport  in  16*N_CH  destination UDP port.
- ch_data  in  8*N_CH  first-word-fall-through payload byte.
- ch_rd  out  N_CH  pops one payload byte.
- ch_done  out  N_CH  one-cycle pulse: packet consumed.
- ch_err  out  N_CH  one-cycle pulse with ch_done: packet dropped.
- local_enable  in  1  permits new frame starts.
- local_mac, local_ip, local_port, local_gateway  in  48, 32, 16, 8  local parameters.
- arp_cache_addr  out  8 and arp_cache_rd_data  in  48  ARP lookup, 1-cycle read latency.
- mac_tx_data  out  8, mac_tx_dvld  out  1, mac_tx_ack  in  1  MAC byte stream.
- tx_pkt_count  out  32  frames sent, wraps.

Function
REQ-006 SHALL implement states IDLE, LOOKUP, CSUM, WAIT_ACK, HDR, DATA, PAD, DISCARD, GAP.
REQ-007 In IDLE, with local_enable high and any ch_valid high, SHALL grant round-robin: the lowest index above the last grant, wrapping; grant latched until ch_done.
REQ-008 Granted ch_len of 0 or greater than MAX_PAYLOAD SHALL go to DISCARD.
- DISCARD: assert ch_rd for ch_len cycles (0 cycles if len 0).
- Then pulse ch_done and ch_err together, return to IDLE.
- mac_tx_dvld SHALL stay low throughout.
REQ-009 arp_cache_addr SHALL be local_gateway when destip[31:8] differs from local_ip[31:8], else destip[7:0]; SHALL hold the dest MAC in LOOKUP for 2 cycles.
REQ-010 CSUM SHALL last exactly 3 cycles and produce the ones-complement IPv4 header checksum.
- Fields: 0x4500, total length, ip_id, 0x4000, 0xFF11, local_ip, destip.
- Carries are folded twice.
REQ-011 The frame SHALL be 42 header bytes, then payload, then zero pad.
- Header: dest MAC, local_mac, 0x0800, IPv4 header with TTL 0xFF and proto 0x11, UDP srcport=local_port.
- Lengths: IP total = len+28, UDP length = len+8, UDP checksum 0x0000.
- All fields big-endian.
REQ-012 WAIT_ACK SHALL drive mac_tx_dvld=1 with byte 0 on mac_tx_data; the cycle mac_tx_ack is sampled high counts as byte 0 accepted.
REQ-013 After ack, SHALL present byte k in the k-th following cycle with mac_tx_dvld continuously high; mac_tx_ack is ignored after the first.
REQ-014 In DATA, mac_tx_data SHALL equal ch_data of the grant combinationally, with ch_rd high in the same cycle, for exactly ch_len cycles.
REQ-015 If 42+len < 60, PAD SHALL emit 0x00 bytes until 60 bytes total.
REQ-016 On the last frame byte SHALL pulse ch_done (ch_err low), increment ip_id and tx_pkt_count, then hold GAP for IFG_CYCLES with mac_tx_dvld low.
REQ-017 local_enable falling mid-frame SHALL NOT truncate the frame; only new grants are blocked.
REQ-018 ip_id (16 bit) and tx_pkt_count (32 bit) SHALL wrap to 0 without side effects.
REQ-019 ch_valid dropping after a grant is a protocol violation; behaviour is unspecified, but the FSM SHALL still return to IDLE.

Reset
REQ-020 mac_rst_n low SHALL asynchronously force:
- state IDLE.
- mac_tx_dvld, ch_rd, ch_done, ch_err, tx_pkt_count, ip_id, mac_tx_data = 0.
- round-robin pointer = N_CH-1, so channel 0 wins first.
REQ-021 Reset mid-frame SHALL abort immediately: dvld low in the asserting cycle, and no ch_done for the aborted packet.

Verification
REQ-022 Ch0 len=100, destip in subnet, ack 5 cycles after dvld -> 142 contiguous bytes; IP len 0x0080, UDP len 0x006C, checksum matches reference model; ch_done[0] once.
REQ-023 Ch1 len=4 -> 60-byte frame; bytes 46..59 = 0x00; exactly 4 ch_rd pulses.
REQ-024 ch_valid=2'b11 held for 4 packets -> grants 0,1,0,1; ip_id 0,1,2,3; dvld low at least 12 cycles between frames.
REQ-025 Ch0 len=1500 -> no dvld, 1500 ch_rd pulses, ch_done[0] and ch_err[0] together; tx_pkt_count unchanged.
REQ-026 destip off-subnet -> arp_cache_addr = local_gateway; frame uses the returned MAC.
REQ-027 mac_rst_n low at payload byte 10 -> dvld 0 the same cycle, no ch_done; after release, channel 0 is granted first.
